barrel_shifter_4_bit: RTL and testbench
=======================================

BARREL_SHIFTER_4_BIT -- requirements
Module: barrel_shifter_4_bit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL expose exactly these ports:
- Clock_In  input  1  rising-edge clock
- Reset_N_In  input  1  asynchronous active-low reset
- Enable_In  input  1  1 = capture a new result at the clock edge; 0 = hold outputs
- Shifter_Mode_In  input  3  operation select (REQ-004)
- Shift_Bits_Length_In  input  2  shift/rotate amount N, 0..3
- Carry_In  input  1  carry used by the through-carry rotates
- Data_In  input  4  operand
- Shifted_Data_Out  output  4  registered result
- Carry_Out  output  1  registered carry result

Function
REQ-003 When Enable_In=1, the block SHALL register the combinational result on each rising Clock_In edge (latency 1 cycle); when Enable_In=0, both outputs SHALL hold their values.
REQ-004 Mode encoding SHALL be:
- 0 LSL, logical shift left
- 1 LSR, logical shift right
- 2 ASL, arithmetic shift left
- 3 ASR, arithmetic shift right
- 4 ROL, rotate left
- 5 ROR, rotate right
- 6 RLC, rotate left through carry
- 7 RRC, rotate right through carry
REQ-005 For N=0, every mode SHALL give Shifted_Data_Out=Data_In and Carry_Out=Carry_In.
REQ-006 LSL/ASL, N>0: data = Data_In<<N, zero fill; Carry_Out = Data_In[4-N], the last bit shifted out. ASL SHALL behave identically to LSL.
REQ-007 LSR, N>0: data = Data_In>>N, zero fill; Carry_Out = Data_In[N-1].
REQ-008 ASR, N>0: data = Data_In>>N, vacated bits filled with Data_In[3]; Carry_Out = Data_In[N-1].
REQ-009 ROL, N>0: data = 4-bit rotate left by N; Carry_Out = resulting bit 0 (Data_In[4-N]).
REQ-010 ROR, N>0: data = 4-bit rotate right by N; Carry_Out = resulting bit 3 (Data_In[N-1]).
REQ-011 RLC: the 5-bit word {Carry_In,Data_In} SHALL be rotated left by N; result MSB goes to Carry_Out and the low 4 bits to Shifted_Data_Out.
REQ-012 RRC: the 5-bit word {Carry_In,Data_In} SHALL be rotated right by N; result MSB goes to Carry_Out and the low 4 bits to Shifted_Data_Out.
REQ-013 The shift/rotate datapath SHALL be purely combinational, free of latches, and its output SHALL be fully defined for all 8 modes and all 4 shift amounts.
REQ-014 Input changes between clock edges SHALL NOT affect the outputs until the next enabled edge.

Reset
REQ-015 Reset_N_In=0 SHALL immediately force Shifted_Data_Out=4'h0 and Carry_Out=0, independent of Clock_In and Enable_In.
REQ-016 After reset deasserts, the first enabled rising edge SHALL load a valid result.
REQ-017 Reset asserted mid-operation SHALL discard any pending result; no partial state survives.

Structure
REQ-018 The mode encodings (REQ-004) SHALL be localparams in a shared package, barrel_shifter_pkg, imported by RTL and bench.
REQ-019 One combinational sub-module, barrel_shifter_core (mode, N, carry, data -> data, carry), SHALL be instantiated and followed by the output register stage.

Verification
REQ-020 The bench SHALL apply reset, then Enable_In=1, LSL, N=1, C=0, D=1011; after 1 edge the outputs SHALL be D=0110, Cout=1.
REQ-021 ASR, N=2, D=1001 -> D=1110, Cout=0; LSR, N=3, D=1000 -> D=0001, Cout=0.
REQ-022 ROR, N=1, D=0011 -> D=1001, Cout=1; ROL, N=0, C=1, D=0101 -> D=0101, Cout=1.
REQ-023 RLC, N=2, C=1, D=0101 -> D=0110, Cout=1; RRC, N=1, C=0, D=0011 -> D=0001, Cout=1.
REQ-024 With Enable_In=0, changing all inputs over 3 edges SHALL leave the outputs unchanged.
REQ-025 Asserting Reset_N_In between clock edges SHALL clear the outputs to 0/0 without waiting for a clock edge.
REQ-026 An exhaustive random check of all 8 modes, all 4 values of N, both carry values and all 16 data values SHALL match a reference model.

Source files
------------

// File: rtl/barrel_shifter_pkg.sv
// rtl/barrel_shifter_pkg.sv - shared mode encodings and widths for the 4-bit barrel shifter
package barrel_shifter_pkg;

    localparam int DATA_W = 4;
    localparam int AMT_W  = 2;
    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_LSL = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LSR = 3'd1;
    localparam logic [MODE_W-1:0] MODE_ASL = 3'd2;
    localparam logic [MODE_W-1:0] MODE_ASR = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROL = 3'd4;
    localparam logic [MODE_W-1:0] MODE_ROR = 3'd5;
    localparam logic [MODE_W-1:0] MODE_RLC = 3'd6;
    localparam logic [MODE_W-1:0] MODE_RRC = 3'd7;

endpackage

// File: rtl/barrel_shifter_core.sv
// rtl/barrel_shifter_core.sv - combinational shift/rotate datapath with carry
module barrel_shifter_core
    import barrel_shifter_pkg::*;
(
    input  logic [MODE_W-1:0] i_mode,
    input  logic [AMT_W-1:0]  i_amt,
    input  logic              i_carry,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_carry
);

    logic [DATA_W:0]   w_cd;
    logic [DATA_W:0]   w_lsl;
    logic [DATA_W:0]   w_lsr;
    logic [DATA_W:0]   w_asr;
    logic [DATA_W:0]   w_rlc;
    logic [DATA_W:0]   w_rrc;
    logic [DATA_W-1:0] w_rol;
    logic [DATA_W-1:0] w_ror;

    always_comb begin
        w_cd  = {i_carry, i_data};
        // A spare bit beside the data catches the last bit shifted out as the carry.
        w_lsl = {1'b0, i_data} << i_amt;
        w_lsr = {i_data, 1'b0} >> i_amt;
        w_asr = $signed({i_data, 1'b0}) >>> i_amt;
        w_rol = (i_data << i_amt) | (i_data >> (3'd4 - {1'b0, i_amt}));
        w_ror = (i_data >> i_amt) | (i_data << (3'd4 - {1'b0, i_amt}));
        w_rlc = (w_cd << i_amt) | (w_cd >> (3'd5 - {1'b0, i_amt}));
        w_rrc = (w_cd >> i_amt) | (w_cd << (3'd5 - {1'b0, i_amt}));

        o_data  = i_data;
        o_carry = i_carry;
        if (i_amt != '0) begin
            case (i_mode)
                MODE_LSL, MODE_ASL: {o_carry, o_data} = w_lsl;
                MODE_LSR: begin
                    o_data  = w_lsr[DATA_W:1];
                    o_carry = w_lsr[0];
                end
                MODE_ASR: begin
                    o_data  = w_asr[DATA_W:1];
                    o_carry = w_asr[0];
                end
                MODE_ROL: begin
                    o_data  = w_rol;
                    o_carry = w_rol[0];
                end
                MODE_ROR: begin
                    o_data  = w_ror;
                    o_carry = w_ror[DATA_W-1];
                end
                MODE_RLC: {o_carry, o_data} = w_rlc;
                MODE_RRC: {o_carry, o_data} = w_rrc;
                default: begin
                    o_data  = i_data;
                    o_carry = i_carry;
                end
            endcase
        end
    end

endmodule

// File: rtl/barrel_shifter_4_bit.sv
// rtl/barrel_shifter_4_bit.sv - 4-bit barrel shifter with registered data and carry outputs
module barrel_shifter_4_bit
    import barrel_shifter_pkg::*;
(
    input  logic              Clock_In,
    input  logic              Reset_N_In,
    input  logic              Enable_In,
    input  logic [MODE_W-1:0] Shifter_Mode_In,
    input  logic [AMT_W-1:0]  Shift_Bits_Length_In,
    input  logic              Carry_In,
    input  logic [DATA_W-1:0] Data_In,
    output logic [DATA_W-1:0] Shifted_Data_Out,
    output logic              Carry_Out
);

    logic [DATA_W-1:0] w_data;
    logic              w_carry;
    logic [DATA_W-1:0] r_data;
    logic              r_carry;

    barrel_shifter_core u_core (
        .i_mode  (Shifter_Mode_In),
        .i_amt   (Shift_Bits_Length_In),
        .i_carry (Carry_In),
        .i_data  (Data_In),
        .o_data  (w_data),
        .o_carry (w_carry)
    );

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            r_data  <= '0;
            r_carry <= 1'b0;
        end else if (Enable_In) begin
            r_data  <= w_data;
            r_carry <= w_carry;
        end
    end

    assign Shifted_Data_Out = r_data;
    assign Carry_Out        = r_carry;

endmodule

// File: tb/tb_barrel_shifter_4_bit.sv
// tb/tb_barrel_shifter_4_bit.sv - scoreboard bench for the 4-bit barrel shifter
module tb_barrel_shifter_4_bit;
    import barrel_shifter_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [2:0] mode  = 3'd0;
    logic [1:0] amt   = 2'd0;
    logic       cin   = 1'b0;
    logic [3:0] din   = 4'd0;
    logic [3:0] dout;
    logic       cout;

    typedef struct {
        logic [3:0] d;
        logic       c;
        int         tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    barrel_shifter_4_bit dut (
        .Clock_In             (clk),
        .Reset_N_In           (rst_n),
        .Enable_In            (en),
        .Shifter_Mode_In      (mode),
        .Shift_Bits_Length_In (amt),
        .Carry_In             (cin),
        .Data_In              (din),
        .Shifted_Data_Out     (dout),
        .Carry_Out            (cout)
    );

    task automatic check(input string nm, input int tag, input logic [3:0] ad, input logic ac,
                         input logic [3:0] ed, input logic ec);
        checks++;
        if (ad !== ed || ac !== ec) begin
            errors++;
            $display("FAIL %s #%0d got d=%b c=%b expected d=%b c=%b", nm, tag, ad, ac, ed, ec);
        end
    endtask

    // Independent reference: one bit-step at a time, tracking the carry explicitly.
    task automatic ref_model(input logic [2:0] m, input logic [1:0] n, input logic c_i,
                             input logic [3:0] d_i, output logic [3:0] d_o, output logic c_o);
        logic [3:0] d;
        logic       c;
        d = d_i;
        c = c_i;
        for (int k = 0; k < int'(n); k++) begin
            case (m)
                MODE_LSL, MODE_ASL: begin c = d[3]; d = {d[2:0], 1'b0}; end
                MODE_LSR: begin c = d[0]; d = {1'b0, d[3:1]}; end
                MODE_ASR: begin c = d[0]; d = {d[3], d[3:1]}; end
                MODE_ROL: begin d = {d[2:0], d[3]}; c = d[0]; end
                MODE_ROR: begin d = {d[0], d[3:1]}; c = d[3]; end
                MODE_RLC: {c, d} = {d, c};
                default:  {c, d} = {d[0], c, d[3:1]};
            endcase
        end
        d_o = d;
        c_o = c;
    endtask

    task automatic drive(input logic e, input logic [2:0] m, input logic [1:0] n,
                         input logic c, input logic [3:0] d, input logic [3:0] ed,
                         input logic ec, input int tag);
        exp_t x;
        @(negedge clk);
        en   = e;
        mode = m;
        amt  = n;
        cin  = c;
        din  = d;
        x.d   = ed;
        x.c   = ec;
        x.tag = tag;
        sb.push_back(x);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check("scoreboard", x.tag, dout, cout, x.d, x.c);
        end
    end

    initial begin
        logic [3:0] ed;
        logic       ec;
        int         k;
        int         off;
        logic [9:0] idx;

        #1;
        check("reset_state", 0, dout, cout, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, MODE_LSL, 2'd1, 1'b0, 4'b1011, 4'b0110, 1'b1, 1);
        drive(1'b1, MODE_ASR, 2'd2, 1'b0, 4'b1001, 4'b1110, 1'b0, 2);
        drive(1'b1, MODE_LSR, 2'd3, 1'b0, 4'b1000, 4'b0001, 1'b0, 3);
        drive(1'b1, MODE_ROR, 2'd1, 1'b0, 4'b0011, 4'b1001, 1'b1, 4);
        drive(1'b1, MODE_ROL, 2'd0, 1'b1, 4'b0101, 4'b0101, 1'b1, 5);
        drive(1'b1, MODE_RLC, 2'd2, 1'b1, 4'b0101, 4'b0110, 1'b1, 6);
        drive(1'b1, MODE_RRC, 2'd1, 1'b0, 4'b0011, 4'b0001, 1'b1, 7);
        drive(1'b1, MODE_ASL, 2'd3, 1'b0, 4'b0011, 4'b1000, 1'b1, 8);
        drive(1'b1, MODE_RRC, 2'd1, 1'b0, 4'b0011, 4'b0001, 1'b1, 9);

        drive(1'b0, MODE_LSL, 2'd2, 1'b1, 4'b1111, 4'b0001, 1'b1, 10);
        drive(1'b0, MODE_ROL, 2'd3, 1'b0, 4'b0110, 4'b0001, 1'b1, 11);
        drive(1'b0, MODE_ASR, 2'd1, 1'b1, 4'b1010, 4'b0001, 1'b1, 12);

        drive(1'b1, MODE_LSL, 2'd1, 1'b0, 4'b1011, 4'b0110, 1'b1, 13);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 14, dout, cout, 4'b0000, 1'b0);
        drive(1'b1, MODE_ROL, 2'd1, 1'b1, 4'b1111, 4'b0000, 1'b0, 15);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b1, MODE_ROR, 2'd2, 1'b0, 4'b0110, 4'b1001, 1'b1, 16);

        k   = int'($urandom_range(0, 511)) * 2 + 1;
        off = int'($urandom_range(0, 1023));
        for (int i = 0; i < 1024; i++) begin
            idx = 10'((i * k + off) & 1023);
            ref_model(idx[9:7], idx[6:5], idx[4], idx[3:0], ed, ec);
            drive(1'b1, idx[9:7], idx[6:5], idx[4], idx[3:0], ed, ec, 100 + int'(idx));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
